// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and transmits each byte as a UART 8N1 frame.
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   ena          in   drain enable (gates new pops only; a frame in flight completes)
//   fifo_empty   in   FIFO empty flag
//   fifo_rd_data in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   out  one-cycle pop strobe (registered)
//   tx           out  serial line, idle high (registered)
//   busy         out  high whenever the engine is not idle (registered)
//   byte_count   out  completed frame count, wraps at 256 (registered)
module fifo_uart_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        byte_count
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q;
  logic [7:0]        cnt_q, cnt_d;

  logic baud_done;
  logic pop_req;

  assign baud_done = (baud_q == BAUD_LAST);
  assign pop_req   = ena && !fifo_empty;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= (state_d != IDLE);
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop_req) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (baud_done) state_d = DATA;
      DATA:    if (baud_done && (bit_idx_q == IDX_LAST)) state_d = STOP;
      STOP:    if (baud_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    rd_en_d   = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        rd_en_d = pop_req;
      end
      FETCH: ;
      LOAD: begin
        // Read data is valid now, one cycle after the pop strobe.
        shreg_d = fifo_rd_data;
        tx_d    = 1'b0;
        baud_d  = '0;
      end
      START: begin
        baud_d = baud_done ? '0 : CNT_W'(baud_q + 1'b1);
        if (baud_done) begin
          tx_d      = shreg_q[0];
          bit_idx_d = '0;
        end
      end
      DATA: begin
        baud_d = baud_done ? '0 : CNT_W'(baud_q + 1'b1);
        if (baud_done) begin
          if (bit_idx_q == IDX_LAST) begin
            tx_d = 1'b1;
          end else begin
            // Shift and present the next bit in the same edge.
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
            bit_idx_d = IDX_W'(bit_idx_q + 1'b1);
          end
        end
      end
      STOP: begin
        baud_d = baud_done ? '0 : CNT_W'(baud_q + 1'b1);
        if (baud_done) cnt_d = 8'(cnt_q + 8'd1);
      end
      default: ;
    endcase
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds the DUT, pushed bytes
// go to an expected queue, and a frame monitor decodes tx and compares.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic [7:0] byte_count;

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         rd_pulses   = 0;
  int         frames_done = 0;
  int         last_gap    = 0;
  logic [7:0] exp_cnt     = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Pushes at a negedge; the FIFO model updates fifo_empty after the next posedge.
  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_rd();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!fifo_rd_en && t < 100);
    check("wait_rd_en", 32'(fifo_rd_en), 32'd1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames_done < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frames_done", 32'(frames_done), 32'(n));
  endtask

  // FIFO model: a pop seen in a cycle presents data after the following edge.
  initial begin : fifo_model
    logic pop;
    fifo_empty   = 1'b1;
    fifo_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      pop = fifo_rd_en;
      @(posedge clk);
      #1;
      if (pop) begin
        if (fq.size() == 0) check("pop_while_empty", 32'd1, 32'd0);
        else fifo_rd_data = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  // Pop strobe monitor: counts pulses and flags strobes wider than one cycle.
  initial begin : rd_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        rd_pulses++;
        if (prev) check("rd_en_width", 32'd2, 32'd1);
      end
      prev = (fifo_rd_en === 1'b1);
    end
  end

  // Frame monitor: every tx sample of a frame is compared against the expected byte.
  initial begin : frame_mon
    logic       prev_tx;
    int         hi;
    logic [7:0] eb;
    logic [7:0] rb;
    int         bad;
    int         b;
    logic       expbit;
    bit         aborted;
    prev_tx = 1'b1;
    hi      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt = 8'd0;
        hi      = 0;
        prev_tx = 1'b1;
      end else if (tx === 1'b0 && prev_tx === 1'b1) begin
        last_gap = CPB + hi;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          eb = 8'h00;
        end else begin
          eb = exp_q.pop_front();
        end
        bad     = 0;
        rb      = 8'h00;
        aborted = 1'b0;
        for (int s = 0; s < 10 * CPB; s++) begin
          if (s > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          b = s / CPB;
          expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
          if (tx !== expbit) bad++;
          if (b >= 1 && b <= 8 && (s % CPB) == CPB / 2) rb[b-1] = tx;
        end
        if (aborted) begin
          exp_cnt = 8'd0;
          hi      = 0;
          prev_tx = 1'b1;
        end else begin
          check("frame_data", 32'(rb), 32'(eb));
          check("frame_shape", 32'(bad), 32'd0);
          @(negedge clk);
          exp_cnt = 8'(exp_cnt + 8'd1);
          frames_done++;
          check("byte_count_after_frame", 32'(byte_count), 32'(exp_cnt));
          check("busy_after_stop", 32'(busy), 32'd0);
          hi      = (tx === 1'b1) ? 1 : 0;
          prev_tx = tx;
        end
      end else begin
        if (tx === 1'b1) hi++;
        prev_tx = tx;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int p0;
    int f0;
    int lat;
    rst = 1'b1;
    ena = 1'b1;

    // Reset held with an empty FIFO
    repeat (5) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_count", 32'(byte_count), 32'd0);
    check("idle_pulses", 32'(rd_pulses), 32'd0);

    // Single byte 0xA5 and pop-to-start latency
    p0 = rd_pulses;
    push(8'hA5);
    wait_rd();
    lat = 1;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("pop_to_start_cycles", 32'(lat), 32'd3);
    wait_frames(1, 200);
    repeat (3) @(negedge clk);
    check("a5_pulses", 32'(rd_pulses - p0), 32'd1);
    check("a5_count", 32'(byte_count), 32'd1);
    check("a5_busy", 32'(busy), 32'd0);

    // Back-to-back 0x00, 0xFF
    p0 = rd_pulses;
    push(8'h00);
    push(8'hFF);
    wait_frames(3, 400);
    check("b2b_gap", 32'(last_gap), 32'(CPB + 3));
    repeat (3) @(negedge clk);
    check("b2b_pulses", 32'(rd_pulses - p0), 32'd2);
    check("b2b_count", 32'(byte_count), 32'd3);

    // ena dropped mid-DATA of the first of three queued bytes
    p0 = rd_pulses;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_rd();
    repeat (2 + 3 * CPB) @(negedge clk);
    ena = 1'b0;
    wait_frames(4, 200);
    repeat (20) @(negedge clk);
    check("ena_low_pulses", 32'(rd_pulses - p0), 32'd1);
    check("ena_low_count", 32'(byte_count), 32'd4);
    check("ena_low_busy", 32'(busy), 32'd0);
    check("ena_low_tx", 32'(tx), 32'd1);
    ena = 1'b1;
    wait_frames(6, 400);
    repeat (3) @(negedge clk);
    check("ena_restore_pulses", 32'(rd_pulses - p0), 32'd3);
    check("ena_restore_count", 32'(byte_count), 32'd6);

    // Reset pulse during data bit 3; the aborted byte must not be resent
    f0 = frames_done;
    push(8'h3C);
    push(8'h81);
    wait_rd();
    repeat (2 + 4 * CPB + 1) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("midrst_count", 32'(byte_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_frames(f0 + 1, 300);
    repeat (3) @(negedge clk);
    check("post_rst_count", 32'(byte_count), 32'd1);

    // 256 frames from a clean reset: count wraps 255 -> 0
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    f0 = frames_done;
    for (int i = 0; i < 256; i++) push(8'(i));
    wait_frames(f0 + 256, 256 * 60);
    repeat (3) @(negedge clk);
    check("wrap_count", 32'(byte_count), 32'd0);

    repeat (10) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
